// File: rtl/rom_upload_reader.sv
// Upload read-back engine: serves host byte reads from the main, sound and wave ROM RAMs.
// Optional running CRC-8 of returned bytes when UPLOAD_CRC_EN is defined.
module rom_upload_reader #(
  parameter int unsigned RAM_LAT  = 1,
  parameter logic [15:0] MAIN_END = 16'h8000,
  parameter logic [15:0] SND_BASE = 16'hE000,
  parameter logic [15:0] WAV_BASE = 16'hFF00,
  parameter logic [7:0]  FILL     = 8'hFF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        upload,
  input  logic        rd,
  input  logic [24:0] addr,
  output logic [7:0]  din,
  output logic        ack,
  output logic        busy,
  output logic        overrun,
  output logic [14:0] main_a,
  input  logic [7:0]  main_q,
  output logic [11:0] snd_a,
  input  logic [7:0]  snd_q,
  output logic [15:0] wav_a,
  input  logic [7:0]  wav_q
`ifdef UPLOAD_CRC_EN
  ,
  output logic [7:0]  crc
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  typedef enum logic [1:0] {REG_NONE, REG_MAIN, REG_SND, REG_WAV} region_t;

  state_t      state_q, state_d;
  region_t     region_q, region_d, region_dec;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  din_q, din_d;
  logic        ovr_q, ovr_d;
  logic        upload_q;
  logic        up_fall;
  logic [14:0] main_a_q, main_a_d;
  logic [11:0] snd_a_q, snd_a_d;
  logic [15:0] wav_a_q, wav_a_d;

  assign up_fall = upload_q & ~upload;

  // The upper nine address bits must be clear for any region to match.
  always_comb begin
    region_dec = REG_NONE;
    if (addr[24:16] == 9'd0) begin
      if (addr[15:0] < MAIN_END)
        region_dec = REG_MAIN;
      else if (({1'b0, addr[15:0]} >= {1'b0, SND_BASE}) &&
               ({1'b0, addr[15:0]} <  ({1'b0, SND_BASE} + 17'd4096)))
        region_dec = REG_SND;
      else if (addr[15:0] >= WAV_BASE)
        region_dec = REG_WAV;
    end
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    din_d    = din_q;
    main_a_d = main_a_q;
    snd_a_d  = snd_a_q;
    wav_a_d  = wav_a_q;
    ovr_d    = ovr_q;

    case (state_q)
      S_IDLE: begin
        if (rd && upload) begin
          state_d  = S_ISSUE;
          region_d = region_dec;
          // Address is registered on acceptance so the RAM sees it during ISSUE.
          case (region_dec)
            REG_MAIN: main_a_d = addr[14:0];
            REG_SND:  snd_a_d  = addr[11:0];
            REG_WAV:  wav_a_d  = addr[15:0];
            default:  ;
          endcase
        end
      end
      S_ISSUE: begin
        if (!upload) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = 2'(RAM_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!upload) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_d == 2'd0) begin
            state_d = S_RESP;
            case (region_q)
              REG_MAIN: din_d = main_q;
              REG_SND:  din_d = snd_q;
              REG_WAV:  din_d = wav_q;
              default:  din_d = FILL;
            endcase
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (up_fall)
      ovr_d = 1'b0;
    else if (rd && (state_q != S_IDLE))
      ovr_d = 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      region_q <= REG_NONE;
      cnt_q    <= 2'd0;
      din_q    <= 8'h00;
      main_a_q <= 15'd0;
      snd_a_q  <= 12'd0;
      wav_a_q  <= 16'd0;
      ovr_q    <= 1'b0;
      upload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      main_a_q <= main_a_d;
      snd_a_q  <= snd_a_d;
      wav_a_q  <= wav_a_d;
      ovr_q    <= ovr_d;
      upload_q <= upload;
    end
  end

  assign din     = din_q;
  assign ack     = (state_q == S_RESP);
  assign busy    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  assign overrun = ovr_q;
  assign main_a  = main_a_q;
  assign snd_a   = snd_a_q;
  assign wav_a   = wav_a_q;

`ifdef UPLOAD_CRC_EN
  logic       up_rise;
  logic [7:0] crc_q, crc_d;

  // CRC-8, polynomial 0x07, MSB first.
  function automatic logic [7:0] crc8_update(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++)
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    return r;
  endfunction

  assign up_rise = upload & ~upload_q;

  always_comb begin
    crc_d = crc_q;
    if (up_rise)
      crc_d = 8'h00;
    else if (state_q == S_RESP)
      crc_d = crc8_update(crc_q, din_q);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)
      crc_q <= 8'h00;
    else
      crc_q <= crc_d;
  end

  assign crc = crc_q;
`endif

endmodule

// File: tb/tb_rom_upload_reader.sv
// Bench for rom_upload_reader: two instances (RAM_LAT 1 and 3) on shared stimulus,
// checked every cycle against a transaction-level reference model.
module tb_rom_upload_reader;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        upload;
  logic        rd;
  logic [24:0] addr;

  always #5 clk_sys = ~clk_sys;

  logic [7:0] main_mem [32768];
  logic [7:0] snd_mem  [4096];
  logic [7:0] wav_mem  [65536];

  logic [7:0]  din_w    [2];
  logic        ack_w    [2];
  logic        busy_w   [2];
  logic        ovr_w    [2];
  logic [14:0] main_a_w [2];
  logic [11:0] snd_a_w  [2];
  logic [15:0] wav_a_w  [2];
  logic [7:0]  main_q_w [2];
  logic [7:0]  snd_q_w  [2];
  logic [7:0]  wav_q_w  [2];
`ifdef UPLOAD_CRC_EN
  logic [7:0]  crc_w    [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [14:0] mp [3];
    logic [11:0] sp [3];
    logic [15:0] wp [3];

    // Synchronous RAM read ports with L cycles of latency.
    always @(posedge clk_sys) begin
      mp[0] <= main_a_w[g]; mp[1] <= mp[0]; mp[2] <= mp[1];
      sp[0] <= snd_a_w[g];  sp[1] <= sp[0]; sp[2] <= sp[1];
      wp[0] <= wav_a_w[g];  wp[1] <= wp[0]; wp[2] <= wp[1];
    end
    assign main_q_w[g] = main_mem[mp[L-1]];
    assign snd_q_w[g]  = snd_mem[sp[L-1]];
    assign wav_q_w[g]  = wav_mem[wp[L-1]];

    rom_upload_reader #(.RAM_LAT(L)) u_dut (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .upload  (upload),
      .rd      (rd),
      .addr    (addr),
      .din     (din_w[g]),
      .ack     (ack_w[g]),
      .busy    (busy_w[g]),
      .overrun (ovr_w[g]),
      .main_a  (main_a_w[g]),
      .main_q  (main_q_w[g]),
      .snd_a   (snd_a_w[g]),
      .snd_q   (snd_q_w[g]),
      .wav_a   (wav_a_w[g]),
      .wav_q   (wav_q_w[g])
`ifdef UPLOAD_CRC_EN
      ,
      .crc     (crc_w[g])
`endif
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got %h expected %h", nm, g, act, exp);
    end
  endtask

  // Reference model state: one outstanding transaction per instance.
  int          cyc;
  bit          prev_up;
  bit          m_pend  [2];
  int          m_ack   [2];
  logic [7:0]  m_byte  [2];
  logic [7:0]  e_din   [2];
  bit          e_ovr   [2];
  logic [14:0] e_ma    [2];
  logic [11:0] e_sa    [2];
  logic [15:0] e_wa    [2];
  logic [7:0]  e_crc   [2];
  int          ack_cnt [2];
  int          last_ack[2];

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  // CRC as polynomial remainder of ((crc ^ d) * x^8) mod 0x107.
  function automatic logic [7:0] crc_ref(input logic [7:0] c, input logic [7:0] d);
    logic [15:0] v;
    v = {c ^ d, 8'h00};
    for (int b = 15; b >= 8; b--)
      if (v[b]) v = v ^ (16'h0107 << (b - 8));
    return v[7:0];
  endfunction

  task automatic compare();
    for (int g = 0; g < 2; g++) begin
      bit ea, eb;
      ea = m_pend[g] && (cyc == m_ack[g]);
      eb = m_pend[g] && (cyc <  m_ack[g]);
      chk("ack", g, ack_w[g], ea);
      chk("busy", g, busy_w[g], eb);
      chk("din", g, din_w[g], e_din[g]);
      chk("overrun", g, ovr_w[g], e_ovr[g]);
      chk("main_a", g, main_a_w[g], e_ma[g]);
      chk("snd_a", g, snd_a_w[g], e_sa[g]);
      chk("wav_a", g, wav_a_w[g], e_wa[g]);
`ifdef UPLOAD_CRC_EN
      chk("crc", g, crc_w[g], e_crc[g]);
`endif
      if (ack_w[g] === 1'b1) begin
        ack_cnt[g]++;
        last_ack[g] = cyc;
      end
    end
  endtask

  task automatic advance(input bit r, input bit u, input logic [24:0] a);
    bit fall, rise;
    fall = prev_up && !u;
    rise = !prev_up && u;
    for (int g = 0; g < 2; g++) begin
      bit was_pend, ackn, busyn;
      was_pend = m_pend[g];
      ackn  = m_pend[g] && (cyc == m_ack[g]);
      busyn = m_pend[g] && (cyc <  m_ack[g]);
      if (rise)      e_crc[g] = 8'h00;
      else if (ackn) e_crc[g] = crc_ref(e_crc[g], e_din[g]);
      if (ackn)                             m_pend[g] = 1'b0;
      else if (busyn && !u)                 m_pend[g] = 1'b0;
      else if (busyn && cyc == m_ack[g]-1)  e_din[g]  = m_byte[g];
      if (!was_pend && r && u) begin
        m_pend[g] = 1'b1;
        m_ack[g]  = cyc + lat(g) + 2;
        if (a[24:16] != 0)                     m_byte[g] = 8'hFF;
        else if (a < 25'h8000) begin           m_byte[g] = main_mem[a[14:0]]; e_ma[g] = a[14:0]; end
        else if (a >= 25'hE000 && a < 25'hF000) begin m_byte[g] = snd_mem[a[11:0]]; e_sa[g] = a[11:0]; end
        else if (a >= 25'hFF00) begin          m_byte[g] = wav_mem[a[15:0]]; e_wa[g] = a[15:0]; end
        else                                   m_byte[g] = 8'hFF;
      end
      if (fall)                  e_ovr[g] = 1'b0;
      else if (r && was_pend)    e_ovr[g] = 1'b1;
    end
    prev_up = u;
    cyc++;
  endtask

  task automatic step(input bit r, input bit u, input logic [24:0] a);
    @(negedge clk_sys);
    compare();
    rd = r; upload = u; addr = a;
    advance(r, u, a);
  endtask

  task automatic idle(input int n, input bit u);
    for (int i = 0; i < n; i++) step(1'b0, u, 25'd0);
  endtask

  function automatic logic [24:0] rand_addr();
    logic [24:0] edges [11];
    int k;
    edges = '{25'h7FFF, 25'h8000, 25'hDFFF, 25'hE000, 25'hEFFF, 25'hF000,
              25'hFEFF, 25'hFF00, 25'hFFFF, 25'h10000, 25'h1FF0000};
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3: return 25'($urandom_range(0, 16'h7FFF));
      4:          return edges[$urandom_range(0, 10)];
      5, 6:       return 25'($urandom_range(16'hE000, 16'hEFFF));
      7:          return 25'($urandom_range(16'hFF00, 16'hFFFF));
      8:          return 25'($urandom_range(16'h8000, 16'hDFFF));
      default:    return 25'($urandom);
    endcase
  endfunction

  initial begin
    int c0, a0;
    bit u;
    for (int i = 0; i < 32768; i++) main_mem[i] = 8'($urandom);
    for (int i = 0; i < 4096;  i++) snd_mem[i]  = 8'($urandom);
    for (int i = 0; i < 65536; i++) wav_mem[i]  = 8'($urandom);
    main_mem[16'h0123] = 8'h5A;
    main_mem[16'h0000] = 8'h3C;
    main_mem[16'h0010] = 8'h01;
    main_mem[16'h0011] = 8'h02;
    snd_mem[12'hFFF]   = 8'h11;
    wav_mem[16'hFF80]  = 8'hC3;

    cyc = 0; prev_up = 1'b0;
    for (int g = 0; g < 2; g++) begin
      m_pend[g] = 0; m_ack[g] = 0; m_byte[g] = 0; e_din[g] = 0; e_ovr[g] = 0;
      e_ma[g] = 0; e_sa[g] = 0; e_wa[g] = 0; e_crc[g] = 0; ack_cnt[g] = 0; last_ack[g] = -1;
    end

    reset_n = 1'b0; rd = 1'b0; upload = 1'b0; addr = '0;
    repeat (3) @(negedge clk_sys);
    for (int g = 0; g < 2; g++) begin
      chk("rst_din", g, din_w[g], 8'h00);
      chk("rst_ack", g, ack_w[g], 1'b0);
      chk("rst_busy", g, busy_w[g], 1'b0);
      chk("rst_overrun", g, ovr_w[g], 1'b0);
      chk("rst_addrs", g, {main_a_w[g], snd_a_w[g], wav_a_w[g]}, 0);
    end
    reset_n = 1'b1;

    // Main read at 0x0123.
    step(0, 1, 0);
    c0 = cyc; step(1, 1, 25'h0123); idle(7, 1);
    chk("main_lat", 0, last_ack[0] - c0, 3);
    chk("main_lat", 1, last_ack[1] - c0, 5);
    chk("main_din", 0, din_w[0], 8'h5A);
    chk("main_addr", 0, {main_a_w[0], snd_a_w[0], wav_a_w[0]}, {15'h123, 12'h0, 16'h0});

    // Sound region top edge.
    step(1, 1, 25'hEFFF); idle(7, 1);
    chk("snd_din", 0, din_w[0], 8'h11);
    chk("snd_a", 0, snd_a_w[0], 12'hFFF);

    // Unmapped: just past sound region, and upper address bits set.
    a0 = ack_cnt[0];
    step(1, 1, 25'hF000); idle(7, 1);
    chk("none_din", 0, din_w[0], 8'hFF);
    chk("none_addr", 0, {main_a_w[0], snd_a_w[0], wav_a_w[0]}, {15'h123, 12'hFFF, 16'h0});
    step(1, 1, 25'h10123); idle(7, 1);
    chk("hi_din", 1, din_w[1], 8'hFF);
    chk("none_acks", 0, ack_cnt[0] - a0, 2);

    // Overrun: second rd one cycle after the first.
    a0 = ack_cnt[0];
    step(1, 1, 25'h0000); step(1, 1, 25'h0000); idle(7, 1);
    chk("ovr_acks", 0, ack_cnt[0] - a0, 1);
    chk("ovr_set", 0, ovr_w[0], 1'b1);
    chk("ovr_din", 0, din_w[0], 8'h3C);
    step(0, 0, 0); step(0, 0, 0);
    chk("ovr_clr", 0, ovr_w[0], 1'b0);

    // Abort: upload drops during WAIT.
    a0 = ack_cnt[0];
    step(0, 1, 0);
    step(1, 1, 25'hFF10); step(0, 1, 0); step(0, 0, 0); idle(7, 0);
    chk("abort_acks", 0, ack_cnt[0] - a0, 0);
    chk("abort_busy", 1, busy_w[1], 1'b0);
    chk("abort_din", 0, din_w[0], 8'h3C);

    // Wave read, latency sweep.
    step(0, 1, 0);
    c0 = cyc; step(1, 1, 25'hFF80); idle(7, 1);
    chk("wav_lat", 1, last_ack[1] - c0, 5);
    chk("wav_din", 1, din_w[1], 8'hC3);
    chk("wav_a", 0, wav_a_w[0], 16'hFF80);

`ifdef UPLOAD_CRC_EN
    step(0, 0, 0); step(0, 1, 0);
    step(1, 1, 25'h0010); idle(7, 1);
    chk("crc_first", 0, crc_w[0], 8'h07);
    step(1, 1, 25'h0011); idle(7, 1);
    chk("crc_second", 1, crc_w[1], 8'h1B);
`endif

    // Model pinned against literals.
    chk("model_crc", 0, crc_ref(8'h00, 8'h01), 8'h07);
    chk("model_crc2", 0, crc_ref(8'h07, 8'h02), 8'h1B);

    // Randomized traffic.
    u = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (u) u = ($urandom_range(0, 99) >= 2);
      else   u = ($urandom_range(0, 99) < 20);
      step(($urandom_range(0, 99) < 30), u, rand_addr());
    end
    idle(8, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
